// File: rtl/uart_periph.sv
// uart_periph: memory-mapped 8N1 UART (CSR/DIV/TXDATA/RXDATA at 0xB000_0000..3).
// Receiver is built only when UART_RX_EN is defined; otherwise TX-only.
module uart_periph (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] uart_write_address,
  input  logic [31:0] uart_write_data,
  input  logic        uart_write_enable,
  input  logic [31:0] uart_read_address,
  output logic [31:0] uart_read_data,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam logic [31:0] A_CSR = 32'hB000_0000;
  localparam logic [31:0] A_DIV = 32'hB000_0001;
  localparam logic [31:0] A_TXD = 32'hB000_0002;
  localparam logic [31:0] A_RXD = 32'hB000_0003;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  logic        r_tx_en, r_rx_en, r_uart_en, r_rx_valid, r_frame_err;
  logic [15:0] r_div;
  logic [7:0]  r_txdata, r_rxdata;
  logic        w_rx_busy, w_unused;
  logic        w_wr_csr, w_wr_div, w_wr_txd;
  logic [15:0] w_div_eff;
  assign w_wr_csr  = uart_write_enable && uart_write_address == A_CSR;
  assign w_wr_div  = uart_write_enable && uart_write_address == A_DIV;
  assign w_wr_txd  = uart_write_enable && uart_write_address == A_TXD;
  assign w_div_eff = (r_div < 16'd3) ? 16'd3 : r_div;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_en   <= 1'b0;
      r_rx_en   <= 1'b0;
      r_uart_en <= 1'b0;
      r_div     <= 16'd433;
      r_txdata  <= 8'd0;
    end else begin
      if (w_wr_csr) begin
        r_tx_en   <= uart_write_data[0];
        r_rx_en   <= uart_write_data[1];
        r_uart_en <= uart_write_data[4];
      end
      if (w_wr_div) r_div <= uart_write_data[15:0];
      if (w_wr_txd) r_txdata <= uart_write_data[7:0];
    end
  end
  state_t      r_tx_st, w_tx_nx;
  logic [15:0] r_tx_div, r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_sh;
  logic        w_tx_go, w_tx_tick, w_tx_send_frame;
  assign w_tx_go   = w_wr_txd && r_uart_en && r_tx_en && r_tx_st == S_IDLE;
  assign w_tx_tick = r_tx_cnt == r_tx_div;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_tx_st <= S_IDLE;
    else       r_tx_st <= w_tx_nx;
  end
  always_comb begin
    w_tx_nx = r_tx_st;
    case (r_tx_st)
      S_IDLE:  w_tx_nx = w_tx_go ? S_START : S_IDLE;
      S_START: w_tx_nx = w_tx_tick ? S_DATA : S_START;
      S_DATA:  w_tx_nx = (w_tx_tick && r_tx_bit == 3'd7) ? S_STOP : S_DATA;
      default: w_tx_nx = w_tx_tick ? S_IDLE : S_STOP;
    endcase
  end
  always_comb begin
    uart_tx         = (r_tx_st == S_START) ? 1'b0 : (r_tx_st == S_DATA) ? r_tx_sh[0] : 1'b1;
    w_tx_send_frame = r_tx_st != S_IDLE;
  end
  // Bit period is r_tx_div+1 clocks; the divisor is frozen for the whole frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_div <= 16'd0;
      r_tx_cnt <= 16'd0;
      r_tx_bit <= 3'd0;
      r_tx_sh  <= 8'd0;
    end else if (w_tx_go) begin
      r_tx_div <= w_div_eff;
      r_tx_cnt <= 16'd0;
      r_tx_bit <= 3'd0;
      r_tx_sh  <= uart_write_data[7:0];
    end else if (r_tx_st != S_IDLE) begin
      r_tx_cnt <= w_tx_tick ? 16'd0 : r_tx_cnt + 16'd1;
      if (w_tx_tick && r_tx_st == S_DATA) begin
        r_tx_sh  <= r_tx_sh >> 1;
        r_tx_bit <= r_tx_bit + 3'd1;
      end
    end
  end
`ifdef UART_RX_EN
  logic        r_rx_s1, r_rx_s2;
  state_t      r_rx_st, w_rx_nx;
  logic [15:0] r_rx_div, r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_sh;
  logic        w_rx_fall, w_rx_tick, w_rx_half, w_rx_done;
  assign w_rx_fall = r_rx_s2 && !r_rx_s1;
  assign w_rx_tick = r_rx_cnt == r_rx_div;
  assign w_rx_half = r_rx_cnt == (r_rx_div >> 1);
  assign w_rx_done = r_rx_st == S_STOP && w_rx_tick;
  assign w_unused  = ^uart_write_data[31:16];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_st <= S_IDLE;
    end else begin
      r_rx_s1 <= uart_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_st <= w_rx_nx;
    end
  end
  always_comb begin
    w_rx_nx = r_rx_st;
    case (r_rx_st)
      S_IDLE:  w_rx_nx = (r_uart_en && r_rx_en && w_rx_fall) ? S_START : S_IDLE;
      S_START: w_rx_nx = w_rx_half ? (r_rx_s2 ? S_IDLE : S_DATA) : S_START;
      S_DATA:  w_rx_nx = (w_rx_tick && r_rx_bit == 3'd7) ? S_STOP : S_DATA;
      default: w_rx_nx = w_rx_tick ? S_IDLE : S_STOP;
    endcase
  end
  assign w_rx_busy = r_rx_st != S_IDLE;
  // The divisor is tracked while idle, so it is the value current at the start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_div <= 16'd0;
      r_rx_cnt <= 16'd0;
      r_rx_bit <= 3'd0;
      r_rx_sh  <= 8'd0;
    end else if (r_rx_st == S_IDLE) begin
      r_rx_div <= w_div_eff;
      r_rx_cnt <= 16'd0;
      r_rx_bit <= 3'd0;
    end else begin
      r_rx_cnt <= ((r_rx_st == S_START) ? w_rx_half : w_rx_tick) ? 16'd0 : r_rx_cnt + 16'd1;
      if (r_rx_st == S_DATA && w_rx_tick) begin
        r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
        r_rx_bit <= r_rx_bit + 3'd1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_rxdata    <= 8'd0;
    end else begin
      r_rx_valid  <= (w_rx_done && r_rx_s2) || (r_rx_valid && !(w_wr_csr && uart_write_data[3]));
      r_frame_err <= (w_rx_done && !r_rx_s2) || (r_frame_err && !(w_wr_csr && uart_write_data[5]));
      if (w_rx_done && r_rx_s2) r_rxdata <= r_rx_sh;
    end
  end
`else
  assign r_rx_valid  = 1'b0;
  assign r_frame_err = 1'b0;
  assign r_rxdata    = 8'd0;
  assign w_rx_busy   = 1'b0;
  assign w_unused    = ^{uart_write_data[31:16], uart_rx};
`endif
  always_comb
    uart_read_data = (uart_read_address == A_CSR) ? {25'd0, w_rx_busy, r_frame_err, r_uart_en, r_rx_valid, w_tx_send_frame, r_rx_en, r_tx_en} :
                     (uart_read_address == A_DIV) ? {16'd0, r_div} :
                     (uart_read_address == A_TXD) ? {24'd0, r_txdata} :
                     (uart_read_address == A_RXD) ? {24'd0, r_rxdata} : 32'd0;
endmodule

// File: tb/tb_uart_periph.sv
// tb_uart_periph: randomized self-checking bench for uart_periph against a bit-timing model.
module tb_uart_periph;
  localparam logic [31:0] A_CSR = 32'hB000_0000;
  localparam logic [31:0] A_DIV = 32'hB000_0001;
  localparam logic [31:0] A_TXD = 32'hB000_0002;
  localparam logic [31:0] A_RXD = 32'hB000_0003;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] wa = '0, wd = '0, ra = '0, rd;
  logic we = 1'b0, tx, drv = 1'b1, loop = 1'b1, rx_line;
  int errors = 0, checks = 0, div_m = 433;
  assign rx_line = loop ? tx : drv;
  always #10 clk = ~clk;
  uart_periph dut (
    .clk(clk), .reset(reset),
    .uart_write_address(wa), .uart_write_data(wd), .uart_write_enable(we),
    .uart_read_address(ra), .uart_read_data(rd),
    .uart_tx(tx), .uart_rx(rx_line)
  );
  function automatic int per(input int d);
    return ((d < 3) ? 3 : d) + 1;
  endfunction
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    @(negedge clk);
    we = 1'b0;
    if (a == A_DIV) div_m = int'(d[15:0]);
  endtask
  task automatic rdv(input logic [31:0] a, output logic [31:0] d);
    ra = a; #1; d = rd;
  endtask
  // Called right after the capturing edge; checks every clock of the frame plus the first idle one.
  task automatic check_frame(input logic [7:0] b, input int d, input logic [31:0] ia, input logic [31:0] idat, input int ik);
    int p, bad, first, blen;
    logic e;
    p = per(d); bad = 0; first = -1; blen = 0;
    ra = A_CSR;
    for (int k = 0; k <= 10 * p; k++) begin
      if (k == ik) begin we = 1'b1; wa = ia; wd = idat; end
      else we = 1'b0;
      #1;
      e = (k >= 10 * p) ? 1'b1 : (k < p) ? 1'b0 : (k >= 9 * p) ? 1'b1 : b[3'(k / p - 1)];
      if (tx !== e || rd[2] !== (k < 10 * p)) begin bad++; if (first < 0) first = k; end
      if (rd[2] === 1'b1) blen++;
      if (k < 10 * p) @(negedge clk);
    end
    we = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL tx_wave byte=%02h div=%0d bad_cycles=%0d first_at=%0d required bad_cycles=0", b, d, bad, first); end
    checks++;
    if (blen !== 10 * p) begin errors++; $display("FAIL tx_busy_len byte=%02h got=%0d required=%0d", b, blen, 10 * p); end
  endtask
  task automatic wait_idle(input int bound);
    int n = 0;
    ra = A_CSR; #1;
    while (rd[2] === 1'b1 && n < bound) begin @(negedge clk); #1; n++; end
    checks++;
    if (rd[2] !== 1'b0) begin errors++; $display("FAIL wait_idle tx_busy=%b after %0d cycles required 0", rd[2], n); end
  endtask
  task automatic drive_frame(input logic [7:0] b, input logic stop, input int p, output logic busy_mid);
    busy_mid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drv = (i == 0) ? 1'b0 : (i == 9) ? stop : b[3'(i - 1)];
      if (i == 5) begin ra = A_CSR; #1; busy_mid = rd[6]; end
      repeat (p) @(negedge clk);
    end
    drv = 1'b1;
  endtask
  task automatic test_reset;
    logic [31:0] v;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b required=1", tx); end
    rdv(A_CSR, v); checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_csr got=%h required=0", v); end
    rdv(A_DIV, v); checks++; if (v !== 32'd433) begin errors++; $display("FAIL reset_div got=%0d required=433", v); end
    rdv(A_TXD, v); checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_txdata got=%h required=0", v); end
    rdv(A_RXD, v); checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_rxdata got=%h required=0", v); end
    rdv(32'hB000_0004, v); checks++; if (v !== 32'd0) begin errors++; $display("FAIL unmapped_read got=%h required=0", v); end
  endtask
  task automatic test_regs;
    logic [31:0] v;
    wr(A_CSR, 32'h57);
    rdv(A_CSR, v); checks++; if (v !== 32'h13) begin errors++; $display("FAIL csr_rw got=%h required=13", v); end
    wr(A_DIV, 32'hABCD_0009);
    rdv(A_DIV, v); checks++; if (v !== 32'h9) begin errors++; $display("FAIL div_rw got=%h required=9", v); end
    wr(32'hB000_0010, 32'hFFFF_FFFF);
    wr(32'h0000_0001, 32'h0000_1234);
    rdv(A_DIV, v); checks++; if (v !== 32'h9) begin errors++; $display("FAIL unmapped_write_div got=%h required=9", v); end
    rdv(A_CSR, v); checks++; if (v !== 32'h13) begin errors++; $display("FAIL unmapped_write_csr got=%h required=13", v); end
    wr(A_DIV, 32'd433);
  endtask
  task automatic test_single_tx;
    wr(A_CSR, 32'h13); wr(A_DIV, 32'd433); wr(A_TXD, 32'h01);
    check_frame(8'h01, 433, '0, '0, -1);
  endtask
  task automatic test_random_tx;
    logic [31:0] v;
    logic [7:0] b;
    int d;
    for (int i = 0; i < 6; i++) begin
      d = $urandom_range(0, 12); b = 8'($urandom);
      wr(A_DIV, 32'(d)); wr(A_TXD, {24'($urandom), b});
      check_frame(b, d, '0, '0, -1);
      rdv(A_TXD, v); checks++; if (v !== {24'd0, b}) begin errors++; $display("FAIL txdata_readback got=%h required=%h", v, b); end
    end
  endtask
  task automatic test_back_to_back;
    logic [7:0] b1, b2;
    b1 = 8'($urandom); b2 = 8'($urandom);
    wr(A_DIV, 32'd5); wr(A_TXD, 32'(b1));
    check_frame(b1, 5, '0, '0, -1);
    wr(A_TXD, 32'(b2));
    check_frame(b2, 5, '0, '0, -1);
  endtask
  task automatic test_busy_drop;
    logic [31:0] v;
    logic [7:0] a, b;
    logic bad;
    a = 8'($urandom); b = ~a;
    wr(A_DIV, 32'd4); wr(A_TXD, 32'(a));
    check_frame(a, 4, A_TXD, 32'(b), 3);
    rdv(A_TXD, v); checks++; if (v !== 32'(b)) begin errors++; $display("FAIL busy_drop_readback got=%h required=%h", v, b); end
    for (int i = 0; i < 2; i++) begin
      wr(A_CSR, (i == 0) ? 32'h12 : 32'h03);
      wr(A_TXD, 32'h00);
      bad = 1'b0; ra = A_CSR;
      repeat (12) begin #1; if (tx !== 1'b1 || rd[2] !== 1'b0) bad = 1'b1; @(negedge clk); end
      checks++; if (bad) begin errors++; $display("FAIL disabled_tx csr_case=%0d line_or_busy_active=1 required=0", i); end
    end
    wr(A_CSR, 32'h13);
  endtask
  task automatic test_div_midframe;
    logic [7:0] a, b;
    a = 8'($urandom); b = 8'($urandom);
    wr(A_DIV, 32'd4); wr(A_TXD, 32'(a));
    check_frame(a, 4, A_DIV, 32'd9, 7);
    div_m = 9;
    wr(A_TXD, 32'(b));
    check_frame(b, div_m, '0, '0, -1);
  endtask
  task automatic test_reset_midframe;
    logic [31:0] v;
    logic [7:0] b;
    wr(A_DIV, 32'd433); wr(A_TXD, 32'h00);
    repeat (1000) @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL pre_reset_tx got=%b required=0", tx); end
    reset = 1'b1; #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_mid_tx got=%b required=1", tx); end
    rdv(A_CSR, v); checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_mid_csr got=%h required=0", v); end
    @(negedge clk); reset = 1'b0; div_m = 433;
    @(negedge clk);
    b = 8'($urandom);
    wr(A_CSR, 32'h13); wr(A_DIV, 32'd6); wr(A_TXD, 32'(b));
    check_frame(b, 6, '0, '0, -1);
  endtask
`ifdef UART_RX_EN
  task automatic wait_rx(input int bound);
    int n = 0;
    ra = A_CSR; #1;
    while (rd[3] !== 1'b1 && n < bound) begin @(negedge clk); #1; n++; end
    checks++;
    if (rd[3] !== 1'b1) begin errors++; $display("FAIL wait_rx_valid rx_valid=%b after %0d cycles required 1", rd[3], n); end
  endtask
  task automatic test_loopback;
    logic [31:0] v;
    logic [7:0] q[$];
    int d, p;
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'h5A, 8'($urandom), 8'($urandom)};
    loop = 1'b1;
    d = $urandom_range(7, 20); p = per(d);
    wr(A_DIV, 32'(d));
    foreach (q[i]) begin
      wait_idle(12 * p);
      wr(A_CSR, 32'h3B);
      rdv(A_CSR, v); checks++; if (v[3] !== 1'b0) begin errors++; $display("FAIL rx_valid_clear got=%b required=0", v[3]); end
      wr(A_TXD, 32'(q[i]));
      wait_rx(12 * p);
      rdv(A_RXD, v); checks++; if (v !== 32'(q[i])) begin errors++; $display("FAIL loopback_rxdata got=%h required=%h", v, q[i]); end
      rdv(A_CSR, v); checks++; if (v[5] !== 1'b0) begin errors++; $display("FAIL loopback_frame_err got=%b required=0", v[5]); end
    end
    wait_idle(12 * p);
    wr(A_TXD, 32'h3C); wait_idle(12 * p);
    wr(A_TXD, 32'hC3); wait_idle(12 * p);
    repeat (2 * p) @(negedge clk);
    rdv(A_RXD, v); checks++; if (v !== 32'hC3) begin errors++; $display("FAIL overwrite_rxdata got=%h required=c3", v); end
  endtask
  task automatic test_frame_err;
    logic [31:0] v;
    logic [7:0] g;
    logic bm;
    int d, p;
    loop = 1'b0; drv = 1'b1;
    d = $urandom_range(7, 15); p = per(d);
    wr(A_DIV, 32'(d)); wr(A_CSR, 32'h3B);
    repeat (3) @(negedge clk);
    g = 8'($urandom);
    drive_frame(g, 1'b1, p, bm);
    checks++; if (bm !== 1'b1) begin errors++; $display("FAIL rx_busy_mid got=%b required=1", bm); end
    repeat (p) @(negedge clk);
    rdv(A_RXD, v); checks++; if (v !== 32'(g)) begin errors++; $display("FAIL driven_rxdata got=%h required=%h", v, g); end
    drive_frame(8'hFF, 1'b0, p, bm);
    repeat (p) @(negedge clk);
    rdv(A_CSR, v); checks++; if (v !== 32'h3B) begin errors++; $display("FAIL frame_err_csr got=%h required=3b", v); end
    rdv(A_RXD, v); checks++; if (v !== 32'(g)) begin errors++; $display("FAIL frame_err_rxdata got=%h required=%h", v, g); end
    wr(A_CSR, 32'h33);
    rdv(A_CSR, v); checks++; if (v !== 32'h1B) begin errors++; $display("FAIL frame_err_clear got=%h required=1b", v); end
    wr(A_CSR, 32'h3B);
    drv = 1'b0; repeat (2) @(negedge clk); drv = 1'b1;
    repeat (2 * p) @(negedge clk);
    rdv(A_CSR, v); checks++; if (v !== 32'h13) begin errors++; $display("FAIL glitch_csr got=%h required=13", v); end
    loop = 1'b1;
    wr(A_CSR, 32'h19); wr(A_TXD, 32'(~g));
    wait_idle(12 * p);
    repeat (2 * p) @(negedge clk);
    rdv(A_CSR, v); checks++; if (v !== 32'h11) begin errors++; $display("FAIL rx_disabled_csr got=%h required=11", v); end
    rdv(A_RXD, v); checks++; if (v !== 32'(g)) begin errors++; $display("FAIL rx_disabled_rxdata got=%h required=%h", v, g); end
  endtask
`else
  task automatic test_rx_absent;
    logic [31:0] v;
    logic bm;
    loop = 1'b1;
    wr(A_CSR, 32'h13); wr(A_DIV, 32'd5); wr(A_TXD, 32'hA5);
    check_frame(8'hA5, 5, '0, '0, -1);
    loop = 1'b0;
    drive_frame(8'hFF, 1'b0, 6, bm);
    repeat (12) @(negedge clk);
    checks++; if (bm !== 1'b0) begin errors++; $display("FAIL rx_absent_busy got=%b required=0", bm); end
    rdv(A_RXD, v); checks++; if (v !== 32'd0) begin errors++; $display("FAIL rx_absent_rxdata got=%h required=0", v); end
    rdv(A_CSR, v); checks++; if (v !== 32'h13) begin errors++; $display("FAIL rx_absent_csr got=%h required=13", v); end
  endtask
`endif
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset;
    test_regs;
    test_single_tx;
    test_random_tx;
    test_back_to_back;
    test_busy_drop;
    test_div_midframe;
    test_reset_midframe;
`ifdef UART_RX_EN
    test_loopback;
    test_frame_err;
`else
    test_rx_absent;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
